// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: filters and deserializes device frames, decodes E0/F0
// prefixes into make/break key events, and holds the arrow-key levels.
module ps2_keyboard_rx #(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 100000
) (
    input  logic       clk,
    input  logic       rst,
    inout  logic       kbd_clk,
    inout  logic       kbd_data,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic [7:0] key_code,
    output logic       key_ext,
    output logic       key_break,
    output logic       key_valid,
    output logic       frame_err,
    output logic       up,
    output logic       down,
    output logic       left,
    output logic       right
);

    localparam int FCW = $clog2(FILTER_LEN) + 1;
    localparam int TCW = $clog2(TIMEOUT) + 1;

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    state_t         state, state_next;
    logic [1:0]     clk_sync, data_sync;
    logic           clk_s, data_s;
    logic           filt_clk, fall;
    logic [FCW-1:0] filt_cnt;
    logic [TCW-1:0] timeout_cnt;
    logic           timeout_hit;
    logic [2:0]     bit_cnt;
    logic [7:0]     shift_reg;
    logic           parity_bit;
    logic           frame_good, frame_bad;
    logic           ext_pend, brk_pend;

    // Both PS/2 lines are receive-only here; they are left to the external pull-ups.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
        end else begin
            clk_sync  <= {clk_sync[0], kbd_clk};
            data_sync <= {data_sync[0], kbd_data};
        end
    end

    assign clk_s  = clk_sync[1];
    assign data_s = data_sync[1];

    // Glitch filter: the clock level must persist FILTER_LEN samples before it is believed.
    always_ff @(posedge clk) begin
        if (rst) begin
            filt_clk <= 1'b1;
            filt_cnt <= '0;
            fall     <= 1'b0;
        end else begin
            fall <= 1'b0;
            if (clk_s != filt_clk) begin
                if (filt_cnt == FCW'(FILTER_LEN - 1)) begin
                    filt_clk <= clk_s;
                    filt_cnt <= '0;
                    fall     <= ~clk_s;
                end else begin
                    filt_cnt <= filt_cnt + 1'b1;
                end
            end else begin
                filt_cnt <= '0;
            end
        end
    end

    assign timeout_hit = (state != IDLE) && (timeout_cnt == TCW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A falling edge always takes priority over a coincident timeout.
    always_comb begin
        state_next = state;
        frame_good = 1'b0;
        frame_bad  = 1'b0;
        if (fall) begin
            case (state)
                IDLE:    if (!data_s) state_next = DATA;
                DATA:    if (bit_cnt == 3'd7) state_next = PARITY;
                PARITY:  state_next = STOP;
                STOP: begin
                    state_next = IDLE;
                    if (data_s && ((^shift_reg) ^ parity_bit)) frame_good = 1'b1;
                    else                                       frame_bad  = 1'b1;
                end
                default: state_next = IDLE;
            endcase
        end else if (timeout_hit) begin
            state_next = IDLE;
            frame_bad  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt     <= '0;
            shift_reg   <= '0;
            parity_bit  <= 1'b0;
            timeout_cnt <= '0;
        end else begin
            if (fall || state == IDLE) timeout_cnt <= '0;
            else                       timeout_cnt <= timeout_cnt + 1'b1;
            if (fall) begin
                case (state)
                    IDLE:   bit_cnt <= '0;
                    DATA: begin
                        shift_reg <= {data_s, shift_reg[7:1]};
                        bit_cnt   <= bit_cnt + 1'b1;
                    end
                    PARITY: parity_bit <= data_s;
                    default: ;
                endcase
            end
        end
    end

    // Byte decode: prefixes accumulate until a real scancode consumes them.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_byte   <= '0;
            rx_valid  <= 1'b0;
            key_code  <= '0;
            key_ext   <= 1'b0;
            key_break <= 1'b0;
            key_valid <= 1'b0;
            frame_err <= 1'b0;
            ext_pend  <= 1'b0;
            brk_pend  <= 1'b0;
            up        <= 1'b0;
            down      <= 1'b0;
            left      <= 1'b0;
            right     <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            key_valid <= 1'b0;
            frame_err <= 1'b0;
            if (frame_good) begin
                rx_byte  <= shift_reg;
                rx_valid <= 1'b1;
                if (shift_reg == 8'hE0) begin
                    ext_pend <= 1'b1;
                end else if (shift_reg == 8'hF0) begin
                    brk_pend <= 1'b1;
                end else begin
                    key_code  <= shift_reg;
                    key_ext   <= ext_pend;
                    key_break <= brk_pend;
                    key_valid <= 1'b1;
                    ext_pend  <= 1'b0;
                    brk_pend  <= 1'b0;
                    if (ext_pend) begin
                        case (shift_reg)
                            8'h75:   up    <= ~brk_pend;
                            8'h72:   down  <= ~brk_pend;
                            8'h6B:   left  <= ~brk_pend;
                            8'h74:   right <= ~brk_pend;
                            default: ;
                        endcase
                    end
                end
            end else if (frame_bad) begin
                frame_err <= 1'b1;
                ext_pend  <= 1'b0;
                brk_pend  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Directed bench for ps2_keyboard_rx: bit-bangs PS/2 frames and checks byte,
// key-event, arrow-level and error behaviour against hand-computed values.
module tb_ps2_keyboard_rx;

    localparam int HALF       = 40;
    localparam int FILTER_LEN = 8;
    localparam int TIMEOUT    = 2000;

    logic clk      = 1'b0;
    logic rst      = 1'b1;
    logic clk_drv  = 1'b1;
    logic data_drv = 1'b1;
    wire  kbd_clk_w;
    wire  kbd_data_w;

    logic [7:0] rx_byte, key_code;
    logic       rx_valid, key_ext, key_break, key_valid, frame_err;
    logic       up, down, left, right;

    assign kbd_clk_w  = clk_drv;
    assign kbd_data_w = data_drv;

    ps2_keyboard_rx #(.FILTER_LEN(FILTER_LEN), .TIMEOUT(TIMEOUT)) dut (
        .clk      (clk),
        .rst      (rst),
        .kbd_clk  (kbd_clk_w),
        .kbd_data (kbd_data_w),
        .rx_byte  (rx_byte),
        .rx_valid (rx_valid),
        .key_code (key_code),
        .key_ext  (key_ext),
        .key_break(key_break),
        .key_valid(key_valid),
        .frame_err(frame_err),
        .up       (up),
        .down     (down),
        .left     (left),
        .right    (right)
    );

    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;
    int rx_cnt = 0, key_cnt = 0, err_cnt = 0, overlap_cnt = 0;
    int rx0 = 0, key0 = 0, err0 = 0;
    logic [7:0] last_rx = '0, last_key = '0;
    logic       last_ext = 1'b0, last_brk = 1'b0;

    // Pulse monitor, sampled just after each active edge.
    always @(posedge clk) begin
        #1;
        if (rx_valid) begin
            rx_cnt++;
            last_rx = rx_byte;
        end
        if (key_valid) begin
            key_cnt++;
            last_key = key_code;
            last_ext = key_ext;
            last_brk = key_break;
        end
        if (frame_err) err_cnt++;
        if (frame_err && (rx_valid || key_valid)) overlap_cnt++;
    end

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        data_drv = b;
        wait_cycles(HALF);
        clk_drv = 1'b0;
        wait_cycles(HALF);
        clk_drv = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad_parity, input logic stop_bit);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit((~^b) ^ bad_parity);
        send_bit(stop_bit);
        data_drv = 1'b1;
        wait_cycles(HALF);
    endtask

    task automatic snap();
        rx0  = rx_cnt;
        key0 = key_cnt;
        err0 = err_cnt;
    endtask

    task automatic check_counts(input string tag, input int rx_n, input int key_n, input int err_n);
        check_output({tag, " rx_valid count"},  32'(rx_cnt - rx0),   32'(rx_n));
        check_output({tag, " key_valid count"}, 32'(key_cnt - key0), 32'(key_n));
        check_output({tag, " frame_err count"}, 32'(err_cnt - err0), 32'(err_n));
    endtask

    task automatic check_key(input string tag, input logic [7:0] code, input logic ext,
                             input logic brk, input logic [3:0] arrows);
        check_output({tag, " key_code"},  32'(last_key), 32'(code));
        check_output({tag, " key_ext"},   32'(last_ext), 32'(ext));
        check_output({tag, " key_break"}, 32'(last_brk), 32'(brk));
        check_output({tag, " arrows"},    32'({up, down, left, right}), 32'(arrows));
    endtask

    task automatic check_all_zero(input string tag);
        check_output({tag, " rx_byte"},  32'(rx_byte),  32'h0);
        check_output({tag, " key_code"}, 32'(key_code), 32'h0);
        check_output({tag, " flags"},
                     32'({rx_valid, key_valid, frame_err, key_ext, key_break, up, down, left, right}),
                     32'h0);
    endtask

    logic [7:0] arrow_codes [4];

    initial begin
        arrow_codes = '{8'h75, 8'h72, 8'h6B, 8'h74};

        rst = 1'b1;
        wait_cycles(5);
        check_all_zero("reset");
        rst = 1'b0;
        wait_cycles(20);

        snap();
        send_frame(8'h1C, 1'b0, 1'b1);
        check_counts("plain 1C", 1, 1, 0);
        check_output("plain 1C rx_byte", 32'(last_rx), 32'h1C);
        check_key("plain 1C", 8'h1C, 1'b0, 1'b0, 4'b0000);

        for (int i = 0; i < 4; i++) begin
            snap();
            send_frame(8'hE0, 1'b0, 1'b1);
            send_frame(arrow_codes[i], 1'b0, 1'b1);
            check_counts($sformatf("make %0h", arrow_codes[i]), 2, 1, 0);
            check_key($sformatf("make %0h", arrow_codes[i]), arrow_codes[i], 1'b1, 1'b0, 4'b1000 >> i);
            snap();
            send_frame(8'hE0, 1'b0, 1'b1);
            send_frame(8'hF0, 1'b0, 1'b1);
            send_frame(arrow_codes[i], 1'b0, 1'b1);
            check_counts($sformatf("break %0h", arrow_codes[i]), 3, 1, 0);
            check_key($sformatf("break %0h", arrow_codes[i]), arrow_codes[i], 1'b1, 1'b1, 4'b0000);
        end

        // Two arrows held together, then a non-extended 75 break must not touch up.
        send_frame(8'hE0, 1'b0, 1'b1);
        send_frame(8'h75, 1'b0, 1'b1);
        send_frame(8'hE0, 1'b0, 1'b1);
        send_frame(8'h74, 1'b0, 1'b1);
        check_key("up+right", 8'h74, 1'b1, 1'b0, 4'b1001);
        send_frame(8'hF0, 1'b0, 1'b1);
        send_frame(8'h75, 1'b0, 1'b1);
        check_key("plain F0 75", 8'h75, 1'b0, 1'b1, 4'b1001);
        send_frame(8'hE0, 1'b0, 1'b1);
        send_frame(8'hF0, 1'b0, 1'b1);
        send_frame(8'h74, 1'b0, 1'b1);
        check_key("release right", 8'h74, 1'b1, 1'b1, 4'b1000);
        send_frame(8'hE0, 1'b0, 1'b1);
        send_frame(8'hF0, 1'b0, 1'b1);
        send_frame(8'h75, 1'b0, 1'b1);
        check_key("release up", 8'h75, 1'b1, 1'b1, 4'b0000);

        snap();
        send_frame(8'h1C, 1'b1, 1'b1);
        check_counts("bad parity", 0, 0, 1);

        snap();
        send_frame(8'hF0, 1'b0, 1'b1);
        send_frame(8'hE0, 1'b1, 1'b1);
        send_frame(8'h1C, 1'b0, 1'b1);
        check_counts("pending cleared", 2, 1, 1);
        check_key("pending cleared", 8'h1C, 1'b0, 1'b0, 4'b0000);

        snap();
        send_frame(8'h1C, 1'b0, 1'b0);
        check_counts("bad stop", 0, 0, 1);
        snap();
        send_frame(8'h29, 1'b0, 1'b1);
        check_counts("after bad stop", 1, 1, 0);
        check_key("after bad stop", 8'h29, 1'b0, 1'b0, 4'b0000);

        snap();
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        data_drv = 1'b1;
        wait_cycles(TIMEOUT + 10);
        check_counts("timeout", 0, 0, 1);
        snap();
        send_frame(8'h1C, 1'b0, 1'b1);
        check_counts("after timeout", 1, 1, 0);
        check_output("after timeout rx_byte", 32'(last_rx), 32'h1C);

        snap();
        clk_drv = 1'b0;
        wait_cycles(FILTER_LEN - 3);
        clk_drv = 1'b1;
        wait_cycles(40);
        check_counts("glitch", 0, 0, 0);
        snap();
        send_frame(8'h1C, 1'b0, 1'b1);
        check_counts("after glitch", 1, 1, 0);

        send_frame(8'hE0, 1'b0, 1'b1);
        send_frame(8'h75, 1'b0, 1'b1);
        check_key("pre-reset up", 8'h75, 1'b1, 1'b0, 4'b1000);
        snap();
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        rst = 1'b1;
        wait_cycles(3);
        check_all_zero("mid-frame reset");
        rst = 1'b0;
        data_drv = 1'b1;
        wait_cycles(20);
        check_counts("mid-frame reset", 0, 0, 0);
        snap();
        send_frame(8'h1C, 1'b0, 1'b1);
        check_counts("after reset", 1, 1, 0);
        check_output("after reset rx_byte", 32'(last_rx), 32'h1C);
        check_key("after reset", 8'h1C, 1'b0, 1'b0, 4'b0000);

        check_output("err/valid overlap", 32'(overlap_cnt), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
